// File: rtl/mem_access_unit.sv
// MEM-stage data memory access unit: issues one registered request per memop, stalls
// upstream until ack or timeout, and registers the MEM/WB outputs (bubble while stalled).
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  WM,
  input  logic [63:0] alu_result,
  input  logic [63:0] mux4_out,
  input  logic [4:0]  RD_n,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        stall,
  output logic [1:0]  WB_out,
  output logic [63:0] mem_data_out,
  output logic [63:0] alu_result_out,
  output logic [4:0]  RD_n_out,
  output logic        err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0] state;
  logic [7:0] count;
  logic       memop;
  logic       timeout;
  logic       unused_wm0;

  assign unused_wm0 = WM[0];
  assign memop      = WM[2] | WM[1];
  assign timeout    = (count == 8'(ACK_TIMEOUT - 1));
  assign stall      = ((state == IDLE) & memop) |
                      ((state == ACCESS) & ~dmem_ack & ~timeout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      count          <= 8'd0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= 64'd0;
      dmem_wdata     <= 64'd0;
      WB_out         <= 2'b00;
      mem_data_out   <= 64'd0;
      alu_result_out <= 64'd0;
      RD_n_out       <= 5'd0;
      err            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memop) begin
            dmem_req       <= 1'b1;
            dmem_we        <= WM[1];
            dmem_addr      <= alu_result;
            dmem_wdata     <= mux4_out;
            count          <= 8'd0;
            state          <= ACCESS;
            WB_out         <= 2'b00;
            alu_result_out <= 64'd0;
            RD_n_out       <= 5'd0;
            mem_data_out   <= 64'd0;
          end else begin
            WB_out         <= WM[4:3];
            alu_result_out <= alu_result;
            RD_n_out       <= RD_n;
            mem_data_out   <= 64'd0;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            // Upstream is frozen during ACCESS, so WM/RD_n still belong to this instruction.
            WB_out         <= WM[4:3];
            alu_result_out <= alu_result;
            RD_n_out       <= RD_n;
            mem_data_out   <= dmem_we ? 64'd0 : dmem_rdata;
            dmem_req       <= 1'b0;
            state          <= IDLE;
          end else begin
            count          <= count + 8'd1;
            WB_out         <= 2'b00;
            alu_result_out <= 64'd0;
            RD_n_out       <= 5'd0;
            mem_data_out   <= 64'd0;
            if (timeout) begin
              dmem_req <= 1'b0;
              err      <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
